mips_bus_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the CPU's single Avalon memory-mapped master port. Instruction-fetch and data-access engines each present a request; the block grants one at a time, drives the Avalon master signals from registers, holds them stable through `waitrequest`, and returns read data plus a one-cycle acknowledge. A watchdog aborts transfers that stall too long.

---
 rtl/mips_bus_arbiter.sv | 135 +++++++++++++
 tb/tb_mips_bus_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_bus_arbiter.sv
// Two-port (instruction fetch / data) arbiter driving one Avalon-MM master port.
// Registered Avalon outputs, one-cycle acks, and a stall watchdog that aborts hung transfers.
module mips_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          RESET_PRIORITY = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        err,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  localparam int unsigned    CW          = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  TIMEOUT_VAL = CW'(TIMEOUT_CYCLES);
  localparam bit             TIMEOUT_ON  = (TIMEOUT_CYCLES != 0);

  typedef enum logic { IDLE, BUS } state_t;
  typedef enum logic { PORT_I = 1'b0, PORT_D = 1'b1 } port_t;

  state_t        state;
  port_t         owner;
  port_t         last_grant;
  port_t         grant_port;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] stall_inc;
  logic          i_elig;
  logic          d_elig;
  logic          timeout_hit;

  // A port is blocked during its own ack cycle so a held req is not re-granted instantly.
  always_comb begin
    i_elig      = i_req & ~i_ack;
    d_elig      = d_req & ~d_ack;
    stall_inc   = stall_cnt + CW'(1);
    timeout_hit = TIMEOUT_ON && (stall_inc == TIMEOUT_VAL);
    if (i_elig && d_elig) grant_port = port_t'(~last_grant);
    else if (d_elig)      grant_port = PORT_D;
    else                  grant_port = PORT_I;
  end

  // NOTE: all state below uses non-blocking assignments so every register samples
  // the pre-edge values of its peers; blocking here would create ordering-dependent logic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= PORT_I;
      last_grant <= port_t'(~RESET_PRIORITY);
      stall_cnt  <= '0;
      address    <= '0;
      writedata  <= '0;
      byteenable <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      err        <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (i_elig || d_elig) begin
            owner      <= grant_port;
            last_grant <= grant_port;
            stall_cnt  <= '0;
            state      <= BUS;
            if (grant_port == PORT_D) begin
              address    <= d_addr;
              writedata  <= d_wdata;
              byteenable <= d_be;
              read       <= ~d_we;
              write      <= d_we;
            end else begin
              address    <= i_addr;
              byteenable <= 4'b1111;
              read       <= 1'b1;
              write      <= 1'b0;
            end
          end
        end
        BUS: begin
          if (!waitrequest) begin
            read  <= 1'b0;
            write <= 1'b0;
            state <= IDLE;
            if (owner == PORT_D) begin
              d_ack <= 1'b1;
              if (read) d_rdata <= readdata;
            end else begin
              i_ack   <= 1'b1;
              i_rdata <= readdata;
            end
          end else if (timeout_hit) begin
            read  <= 1'b0;
            write <= 1'b0;
            err   <= 1'b1;
            state <= IDLE;
            if (owner == PORT_D) begin
              d_ack   <= 1'b1;
              d_rdata <= '0;
            end else begin
              i_ack   <= 1'b1;
              i_rdata <= '0;
            end
          end else if (stall_cnt != '1) begin
            // Saturate so a disabled watchdog never wraps.
            stall_cnt <= stall_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then random traffic
// compared every cycle against a transaction-level model of the arbiter.
module tb_mips_bus_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, waitrequest = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, readdata = '0;
  logic [3:0]  d_be = '0;
  logic [31:0] i_rdata, d_rdata, address, writedata;
  logic        i_ack, d_ack, err, write, read;
  logic [3:0]  byteenable;

  int n_checks = 0;
  int n_pass   = 0;

  mips_bus_arbiter #(.TIMEOUT_CYCLES(TO), .RESET_PRIORITY(1'b0)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_ack(d_ack), .err(err),
    .address(address), .write(write), .read(read), .writedata(writedata),
    .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    else n_pass++;
  endtask

  // ---------------- transaction-level model ----------------
  // One in-flight transfer (owner, direction, latched fields) plus per-port result/ack.
  bit          m_busy = 0, m_owner = 0, m_we = 0, m_last = 1, m_err = 0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic [3:0]  m_be = '0;
  int          m_stalls = 0;
  logic [31:0] m_rdata [2] = '{32'h0, 32'h0};
  bit          m_ack   [2] = '{1'b0, 1'b0};

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 0; m_owner = 0; m_we = 0; m_last = 1; m_err = 0;
      m_addr = '0; m_wdata = '0; m_be = '0; m_stalls = 0;
      m_rdata = '{32'h0, 32'h0}; m_ack = '{1'b0, 1'b0};
    end else begin
      bit was_ack [2];
      bit want [2];
      bit p;
      was_ack = m_ack;
      m_ack   = '{1'b0, 1'b0};
      m_err   = 0;
      if (m_busy) begin
        if (!waitrequest) begin
          if (!m_we) m_rdata[m_owner] = readdata;
          m_ack[m_owner] = 1;
          m_busy = 0;
        end else begin
          m_stalls++;
          if (TO != 0 && m_stalls == TO) begin
            m_rdata[m_owner] = '0;
            m_ack[m_owner] = 1;
            m_err = 1;
            m_busy = 0;
          end
        end
      end else begin
        want[0] = i_req && !was_ack[0];
        want[1] = d_req && !was_ack[1];
        if (want[0] || want[1]) begin
          p = (want[0] && want[1]) ? !m_last : want[1];
          if (p) begin
            m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; m_be = d_be;
          end else begin
            m_we = 0; m_addr = i_addr; m_be = 4'hF;
          end
          m_owner = p; m_last = p; m_busy = 1; m_stalls = 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      check("address",    address,    m_addr);
      check("writedata",  writedata,  m_wdata);
      check("byteenable", {28'h0, byteenable}, {28'h0, m_be});
      check("read",       {31'h0, read},  {31'h0, m_busy && !m_we});
      check("write",      {31'h0, write}, {31'h0, m_busy && m_we});
      check("i_ack",      {31'h0, i_ack}, {31'h0, m_ack[0]});
      check("d_ack",      {31'h0, d_ack}, {31'h0, m_ack[1]});
      check("err",        {31'h0, err},   {31'h0, m_err});
      check("one_ack",    {31'h0, i_ack & d_ack}, 32'h0);
      check("err_w_ack",  {31'h0, err & ~(i_ack | d_ack)}, 32'h0);
      if (m_ack[0]) check("i_rdata", i_rdata, m_rdata[0]);
      if (m_ack[1]) check("d_rdata", d_rdata, m_rdata[1]);
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_address"}, address, 32'h0);
    check({tag, "_wdata"}, writedata, 32'h0);
    check({tag, "_be"}, {28'h0, byteenable}, 32'h0);
    check({tag, "_rdwr"}, {30'h0, read, write}, 32'h0);
    check({tag, "_acks"}, {29'h0, i_ack, d_ack, err}, 32'h0);
    check({tag, "_rdata"}, i_rdata | d_rdata, 32'h0);
  endtask

  initial begin
    logic [31:0] exp_a;
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 0;

    // Single zero-wait fetch.
    i_req = 1; i_addr = 32'hBFC00000; waitrequest = 0; readdata = 32'h24020005;
    @(negedge clk);
    check("t1_read", {31'h0, read}, 32'h1);
    check("t1_addr", address, 32'hBFC00000);
    @(negedge clk);
    check("t1_ack", {31'h0, i_ack}, 32'h1);
    check("t1_rdata", i_rdata, 32'h24020005);
    check("t1_err", {31'h0, err}, 32'h0);
    check("t1_read_drop", {31'h0, read}, 32'h0);
    i_req = 0;
    @(negedge clk);
    check("t1_ack_pulse", {31'h0, i_ack}, 32'h0);

    // Data write with three stall cycles.
    d_req = 1; d_we = 1; d_addr = 32'h00001000; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
    waitrequest = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t2_write", {30'h0, write, read}, 32'h2);
      check("t2_addr", address, 32'h00001000);
      check("t2_wdata", writedata, 32'hDEADBEEF);
      check("t2_be", {28'h0, byteenable}, 32'h3);
      check("t2_noack", {31'h0, d_ack}, 32'h0);
      if (k == 3) waitrequest = 0;
    end
    @(negedge clk);
    check("t2_ack", {30'h0, d_ack, err}, 32'h2);
    check("t2_rdata_kept", d_rdata, 32'h0);
    d_req = 0;
    @(negedge clk);

    // Data read, then a read that times out.
    d_req = 1; d_we = 0; d_addr = 32'h00002000; d_be = 4'hF; readdata = 32'hCAFEF00D;
    @(negedge clk);
    @(negedge clk);
    check("t3_ack", {31'h0, d_ack}, 32'h1);
    check("t3_rdata", d_rdata, 32'hCAFEF00D);
    d_req = 0;
    @(negedge clk);
    d_req = 1; d_addr = 32'h00003000; waitrequest = 1; readdata = 32'h12345678;
    for (int k = 0; k < TO; k++) begin
      @(negedge clk);
      check("t4_stall_read", {31'h0, read}, 32'h1);
      check("t4_stall_noack", {31'h0, d_ack}, 32'h0);
    end
    @(negedge clk);
    check("t4_read_drop", {31'h0, read}, 32'h0);
    check("t4_ack_err", {30'h0, d_ack, err}, 32'h3);
    check("t4_rdata_zero", d_rdata, 32'h0);
    d_req = 0; waitrequest = 0;
    @(negedge clk);
    i_req = 1; i_addr = 32'hBFC00004; readdata = 32'h3C1D8000;
    @(negedge clk);
    @(negedge clk);
    check("t4_next_ack", {30'h0, i_ack, err}, 32'h2);
    check("t4_next_rdata", i_rdata, 32'h3C1D8000);
    i_req = 0;
    @(negedge clk);

    // Async reset in the middle of a stalled fetch.
    i_req = 1; i_addr = 32'hA0000000; waitrequest = 1;
    @(negedge clk);
    check("t5_pre_read", {31'h0, read}, 32'h1);
    #2 reset = 1;
    #1 check_zero("t5_async");
    d_req = 1; d_we = 0; d_addr = 32'h00004000; d_be = 4'hF; waitrequest = 0;
    @(negedge clk);
    reset = 0;

    // Both requesting: I first after reset, then strict alternation.
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 1) begin
        check("t5_first_grant", address, 32'hA0000000);
        check("t5_first_read", {31'h0, read}, 32'h1);
      end
      check("t6_i_ack", {31'h0, i_ack}, {31'h0, (n % 4) == 2});
      check("t6_d_ack", {31'h0, d_ack}, {31'h0, (n % 4) == 0});
      if (n == 10) i_req = 0;
      if (n == 12) d_req = 0;
    end
    @(negedge clk);

    // Fetch-only: re-granted every 3 cycles; i_addr changes during BUS are ignored.
    i_req = 1; i_addr = 32'hC0000000;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      exp_a = 32'hC0000000 + 32'(4 * ((n - 1) / 3));
      check("t7_read", {31'h0, read}, {31'h0, (n % 3) == 1});
      check("t7_ack", {31'h0, i_ack}, {31'h0, (n % 3) == 2});
      if (n % 3 != 0) check("t7_addr", address, exp_a);
      if (n % 3 == 1) i_addr = exp_a + 32'd4;
      if (n == 8) i_req = 0;
    end

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (!i_req || i_ack) begin
        i_req = ($urandom_range(0, 3) != 0);
        i_addr = $urandom;
      end else if ($urandom_range(0, 7) == 0) begin
        i_addr = $urandom;
      end
      if (!d_req || d_ack) begin
        d_req = ($urandom_range(0, 3) != 0);
        d_we = 1'($urandom_range(0, 1));
        d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom);
      end else if ($urandom_range(0, 7) == 0) begin
        d_wdata = $urandom;
      end
      waitrequest = ($urandom_range(0, 9) < 4);
      readdata = $urandom;
    end
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
